// File: rtl/matcher_pkg.sv
// Types shared by the word loader and the matcher-side blocks.
// LOADER_ADDR_W sizes the result record length field and should track the SRAM address width.
package matcher_pkg;

  localparam int unsigned LOADER_ADDR_W = 4;
  localparam logic [7:0]  DELIM_DEFAULT = 8'h20;

  typedef enum logic [2:0] {
    FILL,
    TERM,
    START,
    WAIT,
    REPORT
  } loader_state_t;

  typedef struct packed {
    logic                     found;
    logic [LOADER_ADDR_W-1:0] len;
    logic                     trunc;
    logic                     last;
  } result_t;

endpackage

// File: rtl/word_loader.sv
// Splits a byte stream into words, writes each word plus a 0x00 terminator into the
// input SRAM from address 0, runs one matcher pass per word and reports the outcome.
module word_loader
  import matcher_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = LOADER_ADDR_W,
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  DELIM      = DATA_WIDTH'(DELIM_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  match_start,
  input  logic                  match_done,
  input  logic                  match_found,
  output logic                  result_valid,
  output logic                  result_found,
  output logic [ADDR_WIDTH-1:0] result_len,
  output logic                  result_trunc,
  output logic                  result_last
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CHARS = '1;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  trunc_q, trunc_d;
  logic                  last_q, last_d;

  logic                  ready_d, we_d, start_d, res_valid_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;
  result_t               res_d, res_q;

  logic accept, is_delim;

  assign accept   = in_valid & in_ready;
  assign is_delim = (in_data == DELIM) || (in_data == '0);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    last_d      = last_q;
    we_d        = 1'b0;
    addr_d      = '0;
    din_d       = '0;
    res_valid_d = 1'b0;
    res_d       = '0;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (!is_delim) begin
            if (count_q != MAX_CHARS) begin
              we_d    = 1'b1;
              addr_d  = count_q;
              din_d   = in_data;
              count_d = count_q + ADDR_WIDTH'(1);
            end else begin
              trunc_d = 1'b1;
            end
          end
          // count_d already includes a non-delimiter last byte, so the word test sees it
          if ((is_delim || in_last) && (count_d != '0)) begin
            state_d = TERM;
            last_d  = in_last;
          end else if (in_last) begin
            count_d = '0;
            trunc_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      TERM: begin
        we_d    = 1'b1;
        addr_d  = count_q;
        din_d   = '0;
        state_d = START;
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (match_done) begin
          state_d      = REPORT;
          res_valid_d  = 1'b1;
          res_d.found  = match_found;
          res_d.len    = LOADER_ADDR_W'(count_q);
          res_d.trunc  = trunc_q;
          res_d.last   = last_q;
        end
      end
      REPORT: begin
        count_d = '0;
        trunc_d = 1'b0;
        last_d  = 1'b0;
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ready_d = (state_d == FILL);
    start_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      count_q      <= '0;
      trunc_q      <= 1'b0;
      last_q       <= 1'b0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      match_start  <= 1'b0;
      result_valid <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      trunc_q      <= trunc_d;
      last_q       <= last_d;
      in_ready     <= ready_d;
      mem_we       <= we_d;
      mem_addr     <= addr_d;
      mem_din      <= din_d;
      match_start  <= start_d;
      result_valid <= res_valid_d;
      res_q        <= res_d;
    end
  end

  assign result_found = res_q.found;
  assign result_len   = ADDR_WIDTH'(res_q.len);
  assign result_trunc = res_q.trunc;
  assign result_last  = res_q.last;

endmodule

// File: tb/tb_word_loader.sv
// Self-checking bench for word_loader: directed and random streams against a word-splitting model.
module tb_word_loader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          match_start;
  logic          match_done = 1'b0;
  logic          match_found = 1'b0;
  logic          result_valid;
  logic          result_found;
  logic [AW-1:0] result_len;
  logic          result_trunc;
  logic          result_last;

  always #5 clk = ~clk;

  word_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DELIM(8'h20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .match_start(match_start), .match_done(match_done), .match_found(match_found),
    .result_valid(result_valid), .result_found(result_found), .result_len(result_len),
    .result_trunc(result_trunc), .result_last(result_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  stim[$];
  logic        plan[$];
  logic [11:0] wlog[$], wexp[$];
  logic [6:0]  rlog[$], rexp[$];
  int          idx = 0;
  int          pidx = 0;
  int          delay = 1;
  int          wcnt = 0;
  int          run_len = 0;
  logic        prev_start = 1'b0;
  logic        prev_term = 1'b0;
  bit          gaps = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_str(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic set_plan(input logic [7:0] bits, input int n);
    plan.delete();
    for (int i = 0; i < n; i++) plan.push_back(bits[i]);
    while (plan.size() < 32) plan.push_back(1'($urandom_range(0, 1)));
  endtask

  // Reference: split the stream into words, clip at 15 characters, one result per non-empty word.
  task automatic build_model();
    int   len;
    bit   tr, lst, d;
    int   wi;
    logic [7:0] b;
    wexp.delete();
    rexp.delete();
    len = 0; tr = 0; wi = 0;
    for (int i = 0; i < stim.size(); i++) begin
      b   = stim[i];
      lst = (i == stim.size() - 1);
      d   = (b == 8'h20) || (b == 8'h00);
      if (!d) begin
        if (len < 15) begin
          wexp.push_back({4'(len), b});
          len++;
        end else tr = 1;
      end
      if ((d || lst) && len > 0) begin
        wexp.push_back({4'(len), 8'h00});
        rexp.push_back({plan[wi], 4'(len), tr, lst});
        wi++; len = 0; tr = 0;
      end else if (lst) begin
        len = 0; tr = 0;
      end
    end
  endtask

  task automatic drive();
    if (idx < stim.size()) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = stim[idx];
      in_last  = (idx == stim.size() - 1);
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
    end
  endtask

  task automatic tick();
    logic acc, done_drv, rst_was;
    acc      = in_valid && in_ready && !rst;
    done_drv = match_done && !rst;
    rst_was  = rst;
    @(posedge clk);
    #1;
    if (acc) idx++;
    if (!rst_was) begin
      check("we_and_start", 32'(mem_we & match_start), 0);
      check("result_timing", 32'(result_valid), 32'(done_drv));
      if (match_start && !prev_start) check("start_after_term", 32'(prev_term), 1);
      if (match_start) check("ready_in_wait", 32'(in_ready), 0);
      if (!match_start && prev_start) check("start_width", run_len, delay);
      if (mem_we) wlog.push_back({mem_addr, mem_din});
      if (result_valid) rlog.push_back({result_found, result_len, result_trunc, result_last});
    end
    prev_term  = mem_we && (mem_din == 8'h00);
    prev_start = match_start;
    run_len    = match_start ? run_len + 1 : 0;
    match_done = 1'b0;
    if (match_start) begin
      wcnt++;
      if (wcnt >= delay) begin
        match_done  = 1'b1;
        match_found = (pidx < plan.size()) ? plan[pidx] : 1'b0;
        pidx++;
        wcnt = 0;
      end
    end else wcnt = 0;
  endtask

  task automatic run_stream(input string tag);
    bit ok;
    int nw, nr;
    build_model();
    wlog.delete();
    rlog.delete();
    idx = 0; pidx = 0; ok = 0;
    for (int c = 0; c < 3000; c++) begin
      drive();
      tick();
      if (idx == stim.size() && rlog.size() >= rexp.size() && !match_start && in_ready) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_timeout"}, 32'(ok), 1);
    drive();
    repeat (4) tick();
    check({tag, "_nwrites"}, wlog.size(), wexp.size());
    check({tag, "_nresults"}, rlog.size(), rexp.size());
    nw = (wlog.size() < wexp.size()) ? wlog.size() : wexp.size();
    nr = (rlog.size() < rexp.size()) ? rlog.size() : rexp.size();
    for (int i = 0; i < nw; i++) check({tag, "_write"}, 32'(wlog[i]), 32'(wexp[i]));
    for (int i = 0; i < nr; i++) check({tag, "_result"}, 32'(rlog[i]), 32'(rexp[i]));
  endtask

  initial begin
    bit reached;
    logic [7:0] b;
    int r;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem", {mem_we, mem_addr, mem_din}, 0);
    check("rst_start", 32'(match_start), 0);
    check("rst_result", {result_valid, result_found, result_len, result_trunc, result_last}, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(in_ready), 1);

    gaps = 0; delay = 3;
    set_str("cat"); set_plan(8'b1, 1);
    run_stream("cat");

    gaps = 1; delay = 2;
    set_str("  ab  cd"); set_plan(8'b10, 2);
    run_stream("two_words");

    gaps = 0; delay = 1;
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'h6b);
    stim.push_back(8'h20);
    set_plan(8'b0, 1);
    run_stream("trunc");

    gaps = 0; delay = 40;
    set_str("ab cd"); set_plan(8'b01, 2);
    run_stream("long_wait");

    gaps = 0; delay = 1;
    set_str("ab"); stim.push_back(8'h00); stim.push_back(8'h63);
    set_plan(8'b11, 2);
    run_stream("nul_delim");

    // reset while waiting on the matcher
    delay = 1000;
    set_str("qq"); set_plan(8'b1, 1);
    idx = 0; reached = 0;
    for (int c = 0; c < 50; c++) begin
      drive();
      tick();
      if (match_start) begin
        reached = 1;
        break;
      end
    end
    check("wait_reached", 32'(reached), 1);
    drive();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_start", 32'(match_start), 0);
    check("midrst_ready", 32'(in_ready), 0);
    check("midrst_result", 32'(result_valid), 0);
    check("midrst_we", 32'(mem_we), 0);
    rst = 1'b0;
    delay = 2;
    tick();
    check("midrst_ready_back", 32'(in_ready), 1);
    set_str("x"); set_plan(8'b0, 1);
    run_stream("after_rst");

    // random streams
    gaps = 1;
    for (int k = 0; k < 8; k++) begin
      stim.delete();
      for (int i = 0; i < $urandom_range(1, 30); i++) begin
        r = $urandom_range(0, 9);
        if (r < 2) b = 8'h20;
        else if (r == 2) b = 8'h00;
        else b = 8'h61 + 8'(r - 3);
        stim.push_back(b);
      end
      set_plan(8'b0, 0);
      delay = $urandom_range(1, 5);
      run_stream("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
